// File: rtl/fwrisc_mds_arbiter.sv
// Two-port arbiter/sequencer sharing one mul/div/shift unit; FWRISC_MDS_ARB_RR_EN selects round-robin ties (else req0 priority).
// Latency: accept c0, unit start c1, response c2+L; one operation in flight, next accept after rsp handshake.
// Backpressure: losing/late requesters see ready=0 and hold; a response is held stable until its rsp_ready.
module fwrisc_mds_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic [OP_WIDTH-1:0]   req0_op,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    input  logic [OP_WIDTH-1:0]   req1_op,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_data,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_data,
    output logic [DATA_WIDTH-1:0] mds_in_a,
    output logic [DATA_WIDTH-1:0] mds_in_b,
    output logic [OP_WIDTH-1:0]   mds_op,
    output logic                  mds_in_valid,
    input  logic [DATA_WIDTH-1:0] mds_out,
    input  logic                  mds_out_valid,
    output logic                  busy,
    output logic                  grant_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state, state_nxt;
    logic   any_req;
    logic   win;
    logic   rsp_hs;

    assign any_req = req0_valid | req1_valid;
    assign rsp_hs  = grant_id ? rsp1_ready : rsp0_ready;

`ifdef FWRISC_MDS_ARB_RR_EN
    logic last_grant;

    // Reset to 1 so that req0 takes the first tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            last_grant <= 1'b1;
        else if (state == RESP && rsp_hs)
            last_grant <= grant_id;
    end

    assign win = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
`else
    assign win = ~req0_valid;
`endif

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    req0_ready = ~win;
                    req1_ready = win;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (mds_out_valid)
                    state_nxt = RESP;
            end
            RESP: begin
                if (rsp_hs)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            mds_in_a     <= '0;
            mds_in_b     <= '0;
            mds_op       <= '0;
            mds_in_valid <= 1'b0;
            busy         <= 1'b0;
            grant_id     <= 1'b0;
            rsp0_valid   <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp0_data    <= '0;
            rsp1_data    <= '0;
        end else begin
            state        <= state_nxt;
            mds_in_valid <= (state_nxt == ISSUE);
            busy         <= (state_nxt != IDLE);
            if (state == IDLE && any_req) begin
                mds_in_a <= win ? req1_a  : req0_a;
                mds_in_b <= win ? req1_b  : req0_b;
                mds_op   <= win ? req1_op : req0_op;
                grant_id <= win;
            end
            // Result is steered to the owner's port only; the other port reads zero.
            if (state == WAIT && mds_out_valid) begin
                rsp0_valid <= ~grant_id;
                rsp1_valid <= grant_id;
                rsp0_data  <= grant_id ? '0 : mds_out;
                rsp1_data  <= grant_id ? mds_out : '0;
            end else if (state == RESP && rsp_hs) begin
                rsp0_valid <= 1'b0;
                rsp1_valid <= 1'b0;
                rsp0_data  <= '0;
                rsp1_data  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fwrisc_mds_arbiter.sv
// Bench for fwrisc_mds_arbiter: behavioural unit model with programmable latency,
// vector table of single operations plus tie, spurious-completion and reset sequences.
module tb_fwrisc_mds_arbiter;
    localparam int DW = 32;
    localparam int OW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [OW-1:0] req0_op, req1_op;
    logic          rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [DW-1:0] rsp0_data, rsp1_data;
    logic [DW-1:0] mds_in_a, mds_in_b, mds_out;
    logic [OW-1:0] mds_op;
    logic          mds_in_valid, mds_out_valid, busy, grant_id;

    fwrisc_mds_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .mds_in_a(mds_in_a), .mds_in_b(mds_in_b), .mds_op(mds_op), .mds_in_valid(mds_in_valid),
        .mds_out(mds_out), .mds_out_valid(mds_out_valid),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] unit_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        return (op == 4'd0) ? a * b : ((a + b) ^ {28'h0, op});
    endfunction

    // Unit model: out_valid L cycles after the in_valid cycle.
    int          lat_cur = 3;
    int          cnt;
    logic        model_ov;
    logic [31:0] model_out;
    logic        spur = 1'b0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= 0; model_ov <= 1'b0; model_out <= '0;
        end else if (mds_in_valid) begin
            model_out <= unit_fn(mds_in_a, mds_in_b, mds_op);
            if (lat_cur == 1) model_ov <= 1'b1;
            else begin cnt <= lat_cur - 1; model_ov <= 1'b0; end
        end else if (cnt != 0) begin
            cnt <= cnt - 1; model_ov <= (cnt == 1);
        end else begin
            model_ov <= 1'b0;
        end
    end

    assign mds_out_valid = model_ov | spur;
    assign mds_out       = spur ? 32'hDEAD : model_out;

    typedef struct { logic port; logic [31:0] data; } exp_t;
    exp_t sb[$];

    typedef struct { int port; logic [31:0] a; logic [31:0] b; logic [3:0] op; int lat; int hold; } vec_t;
    vec_t vecs[6];

    task automatic wait_rsp(output int port, output int n);
        port = -1;
        n = 0;
        while (n < 60) begin
            @(negedge clock);
            if (rsp0_valid || rsp1_valid) begin
                port = rsp1_valid ? 1 : 0;
                return;
            end
            n++;
            @(posedge clock); #1;
        end
        chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_rsp(input int p);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk("sb_port", p, {31'd0, e.port});
        chk("sb_data", (p == 0) ? rsp0_data : rsp1_data, e.data);
        chk("grant_id", {31'd0, grant_id}, {31'd0, e.port});
        chk("other_valid", (p == 0) ? rsp1_valid : rsp0_valid, 0);
        chk("other_data", (p == 0) ? rsp1_data : rsp0_data, 0);
    endtask

    task automatic run_op(input int port, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input int lat, input int hold);
        exp_t        e;
        int          p, n;
        logic [31:0] d;
        lat_cur = lat;
        @(posedge clock); #1;
        if (port == 0) begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
        else           begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
        @(negedge clock);
        chk("accept_ready", (port == 0) ? req0_ready : req1_ready, 1);
        chk("loser_ready", (port == 0) ? req1_ready : req0_ready, 0);
        e.port = port[0];
        e.data = unit_fn(a, b, op);
        sb.push_back(e);
        @(posedge clock); #1;
        req0_valid = 0; req1_valid = 0; req0_a = ~a; req1_a = ~a;
        @(negedge clock);
        chk("issue_valid", mds_in_valid, 1);
        chk("issue_a", mds_in_a, a);
        chk("issue_op", mds_op, op);
        @(posedge clock); #1;
        wait_rsp(p, n);
        if (p < 0) return;
        chk("rsp_latency", n, lat);
        chk("rsp_port", p, port);
        chk("hold_a", mds_in_a, a);
        chk("wait_in_valid", mds_in_valid, 0);
        d = (port == 0) ? rsp0_data : rsp1_data;
        for (int h = 0; h < hold; h++) begin
            @(posedge clock); #1;
            if (port == 0) req1_valid = 1; else req0_valid = 1;
            @(negedge clock);
            chk("bp_valid", (port == 0) ? rsp0_valid : rsp1_valid, 1);
            chk("bp_data", (port == 0) ? rsp0_data : rsp1_data, d);
            chk("bp_busy", busy, 1);
            chk("bp_ready", (port == 0) ? req1_ready : req0_ready, 0);
        end
        if (port == 0) rsp0_ready = 1; else rsp1_ready = 1;
        check_rsp(p);
        @(posedge clock); #1;
        rsp0_ready = 0; rsp1_ready = 0; req0_valid = 0; req1_valid = 0;
        @(negedge clock);
        chk("idle_after_hs", busy, 0);
        chk("rsp_drop", rsp0_valid | rsp1_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, n, p, expg;
        vecs[0] = '{0, 32'h6,        32'h7,      4'd0, 3, 0};
        vecs[1] = '{1, 32'd100,      32'd3,      4'd0, 1, 0};
        vecs[2] = '{0, 32'hFFFFFFFF, 32'h2,      4'd1, 2, 0};
        vecs[3] = '{1, 32'd5,        32'd9,      4'd3, 4, 5};
        vecs[4] = '{0, 32'h0,        32'h0,      4'd0, 1, 2};
        vecs[5] = '{1, 32'd123456,   32'd654321, 4'd7, 6, 0};

        reset = 1;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_in_valid", mds_in_valid, 0);
        chk("rst_rsp_valid", rsp0_valid | rsp1_valid, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_in_a", mds_in_a, 0);
        @(negedge clock);
        reset = 0;

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].lat, vecs[i].hold);

        // Completion while idle must be ignored.
        @(posedge clock); #1;
        spur = 1;
        @(negedge clock);
        chk("spur_busy", busy, 0);
        @(posedge clock); #1;
        spur = 0;
        @(negedge clock);
        chk("spur_rsp", rsp0_valid | rsp1_valid, 0);
        chk("spur_data", rsp0_data, 0);
        chk("spur_busy2", busy, 0);

        // Reset during WAIT: everything clears, then req1 is accepted straight away.
        lat_cur = 5;
        @(posedge clock); #1;
        req0_valid = 1; req0_a = 32'h55; req0_b = 32'h3; req0_op = 0;
        @(negedge clock);
        chk("rw_accept", req0_ready, 1);
        @(posedge clock); #1;
        req0_valid = 0;
        @(posedge clock); #1;
        reset = 1;
        #1;
        chk("rw_busy", busy, 0);
        chk("rw_in_valid", mds_in_valid, 0);
        chk("rw_in_a", mds_in_a, 0);
        chk("rw_op", mds_op, 0);
        chk("rw_rsp", rsp0_valid | rsp1_valid, 0);
        chk("rw_grant", grant_id, 0);
        sb.delete();
        @(negedge clock);
        reset = 0;
        run_op(1, 32'd11, 32'd13, 4'd0, 2, 0);

        // Both requesters held valid for four back-to-back operations.
        lat_cur = 2;
        rsp0_ready = 1; rsp1_ready = 1;
        @(posedge clock); #1;
        req0_valid = 1; req0_a = 1; req0_b = 2; req0_op = 0;
        req1_valid = 1; req1_a = 3; req1_b = 4; req1_op = 0;
        for (int k = 0; k < 4; k++) begin
            exp_t e;
`ifdef FWRISC_MDS_ARB_RR_EN
            expg = k % 2;
`else
            expg = 0;
`endif
            got = -1;
            n = 0;
            while (n < 40) begin
                @(negedge clock);
                if (req0_ready || req1_ready) begin
                    got = req1_ready ? 1 : 0;
                    break;
                end
                @(posedge clock); #1;
                n++;
            end
            chk("tie_grant", got, expg);
            chk("tie_one_ready", req0_ready & req1_ready, 0);
            e.port = expg[0];
            e.data = (expg == 0) ? 32'd2 : 32'd12;
            sb.push_back(e);
            @(posedge clock); #1;
            wait_rsp(p, n);
            if (p >= 0) check_rsp(p);
            @(posedge clock); #1;
            if (k == 3) begin req0_valid = 0; req1_valid = 0; end
        end
        rsp0_ready = 0; rsp1_ready = 0;
        @(negedge clock);
        chk("tie_idle", busy, 0);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fwrisc_mds_arbiter.md
# fwrisc_mds_arbiter

Two-requester arbiter and sequencer for one shared `fwrisc_mul_div_shift` unit. It accepts operations from two independent requester ports and issues one at a time to the unit. It waits for the unit's result and returns it to the requester that issued the operation. It sits between the integer pipeline and a coprocessor-style client (or two harts) so that one multi-cycle MUL/DIV/shift unit serves both.

## Interface
- `DATA_WIDTH`, 32, operand/result width; must match the unit.
- `OP_WIDTH`, 4, opcode width; opcodes pass through unchanged.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  request pending.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  DATA_WIDTH  operands.
- `req0_op` / `req1_op`  in  OP_WIDTH  opcode.
- `rsp0_valid` / `rsp1_valid`  out  1  result available.
- `rsp0_ready` / `rsp1_ready`  in  1  requester takes result.
- `rsp0_data` / `rsp1_data`  out  DATA_WIDTH  result.
- `mds_in_a`, `mds_in_b`  out  DATA_WIDTH  to unit `in_a`/`in_b`.
- `mds_op`  out  OP_WIDTH  to unit `op`.
- `mds_in_valid`  out  1  one-cycle start pulse to unit `in_valid`.
- `mds_out`  in  DATA_WIDTH  from unit `out`.
- `mds_out_valid`  in  1  from unit `out_valid`.
- `busy`  out  1  state != IDLE.
- `grant_id`  out  1  owner of the current/last operation.

## Operation
- Reset values:
  - all outputs 0, state IDLE.
  - `last_grant` = 1, so req0 wins the first tie.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any `reqN_valid`, select winner `g`.
  - Assert `reqg_ready` combinationally in that cycle only.
  - Latch a/b/op into the operand registers and set `grant_id`=g.
  - Go to ISSUE.
  - The loser sees `ready`=0 and must hold its request stable.
- ISSUE:
  - `mds_in_valid`=1 for exactly one cycle, with latched operands on `mds_in_a/b/op`.
  - Go to WAIT.
- WAIT:
  - Hold `mds_in_a/b/op` stable with `mds_in_valid`=0.
  - On `mds_out_valid`=1, latch `mds_out` into the result register and go to RESP.
  - No timeout; the unit always completes.
- RESP:
  - `rspg_valid`=1 and `rspg_data`=result, held stable until `rspg_ready`=1.
  - On that handshake, update `last_grant`=g and return to IDLE.
  - `rsp_data` of the non-granted port reads 0.
- Arbitration with both requests valid in IDLE: grant `!last_grant` (round-robin).
- With a single request valid, that requester wins regardless of `last_grant`.
- `mds_out_valid` outside WAIT is ignored and changes no state.
- `reqN_ready` is never asserted outside IDLE; at most one operation is in flight.
- Reset mid-operation:
  - Returns to IDLE immediately and drops all valids.
  - The in-flight result is discarded.
  - The unit shares `reset` and is cleared with the arbiter.

## Timing
- Cycle 0: request accepted (`ready`=1).
- Cycle 1: `mds_in_valid`=1.
- Cycle 1+L: `mds_out_valid`, where L is the unit latency (L ≥ 1).
- Cycle 2+L: `rsp_valid`=1.
- Earliest next acceptance: the cycle after the `rsp` handshake.
- Best-case throughput: one operation per L+3 cycles with `rsp_ready` tied high.
- All outputs are registered except `reqN_ready`, which is a combinational function of state and `req*_valid`.

## Configuration
- `FWRISC_MDS_ARB_RR_EN` defined: round-robin tie-break via `last_grant`, as above.
- `FWRISC_MDS_ARB_RR_EN` undefined:
  - Fixed priority: req0 always wins ties.
  - The `last_grant` register is removed.
  - `grant_id` still reports the owner.
  - All other behaviour is identical.

## Test plan
- Single op: req0 a=0x6, b=0x7, unit modelled with L=3 returning 0x2A.
  - Expect `req0_ready` at c0, `mds_in_valid` at c1, `rsp0_valid` with 0x2A at c5.
  - `rsp1_valid` stays 0.
- Tie, RR enabled: both requesters hold valid for 4 back-to-back ops.
  - Expect grants 0, 1, 0, 1, each response on the correct port.
  - With the macro undefined, expect 0 first and req1 starved while req0 stays valid.
- Backpressure: `rsp1_ready`=0 for 5 cycles after `rsp1_valid`.
  - Expect data stable, `busy`=1 and `req0_ready`=0 throughout.
  - IDLE is reached the cycle after `rsp1_ready` rises.
- Spurious completion: pulse `mds_out_valid` with `mds_out`=0xDEAD in IDLE.
  - Expect no `rsp` valid and no state change.
- Reset mid-WAIT: assert `reset` at c2 of an op.
  - Expect all outputs 0 immediately and no response after reset deasserts.
  - A new req1 is accepted in the first cycle after release.
- Operand hold: change `req0_a` after acceptance.
  - Expect `mds_in_a` to keep the value latched at acceptance through WAIT.
